// File: rtl/logic_gates_pkg.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates_pkg
// Brief    : Shared op_sel encoding for the registered bitwise gate block.
// Revision : 1.0
// ============================================================================
package logic_gates_pkg;

    localparam int OP_SEL_W = 3;

    localparam logic [OP_SEL_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_SEL_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_SEL_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_SEL_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_SEL_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_SEL_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_SEL_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_SEL_W-1:0] OP_PASS = 3'd7;

endpackage
`default_nettype wire

// File: rtl/logic_gates_gate_slice.sv
`default_nettype none
// ============================================================================
// Module   : gate_slice
// Brief    : All seven combinational gate values for a single bit position.
// Revision : 1.0
// ============================================================================
module gate_slice (
    input  logic a,
    input  logic b,
    output logic and_bit,
    output logic or_bit,
    output logic not_bit,
    output logic nand_bit,
    output logic nor_bit,
    output logic xor_bit,
    output logic xnor_bit
);

    assign and_bit  = a & b;
    assign or_bit   = a | b;
    assign not_bit  = ~a;
    assign nand_bit = ~(a & b);
    assign nor_bit  = ~(a | b);
    assign xor_bit  = a ^ b;
    assign xnor_bit = ~(a ^ b);

endmodule
`default_nettype wire

// File: rtl/logic_gates.sv
`default_nettype none
// ============================================================================
// Module   : logic_gates
// Brief    : Registered bitwise gates with op_sel-selected result, 1-cycle latency.
// Revision : 1.0
// ============================================================================
module logic_gates
    import logic_gates_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                in_valid,
    input  logic [OP_SEL_W-1:0] op_sel,
    output logic [WIDTH-1:0]    and_out,
    output logic [WIDTH-1:0]    or_out,
    output logic [WIDTH-1:0]    not_out,
    output logic [WIDTH-1:0]    nand_out,
    output logic [WIDTH-1:0]    nor_out,
    output logic [WIDTH-1:0]    xor_out,
    output logic [WIDTH-1:0]    xnor_out,
    output logic [WIDTH-1:0]    result,
    output logic                out_valid
);

    logic [WIDTH-1:0] w_and, w_or, w_not, w_nand, w_nor, w_xor, w_xnor;
    logic [WIDTH-1:0] w_result;

    logic [WIDTH-1:0] r_and, r_or, r_not, r_nand, r_nor, r_xor, r_xnor;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        gate_slice u_slice (
            .a        (a[i]),
            .b        (b[i]),
            .and_bit  (w_and[i]),
            .or_bit   (w_or[i]),
            .not_bit  (w_not[i]),
            .nand_bit (w_nand[i]),
            .nor_bit  (w_nor[i]),
            .xor_bit  (w_xor[i]),
            .xnor_bit (w_xnor[i])
        );
    end

    always_comb begin
        w_result = a;
        case (op_sel)
            OP_AND:  w_result = w_and;
            OP_OR:   w_result = w_or;
            OP_NOT:  w_result = w_not;
            OP_NAND: w_result = w_nand;
            OP_NOR:  w_result = w_nor;
            OP_XOR:  w_result = w_xor;
            OP_XNOR: w_result = w_xnor;
            OP_PASS: w_result = a;
            default: w_result = a;
        endcase
    end

    // Reset wins over in_valid, so a sample on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_and    <= '0;
            r_or     <= '0;
            r_not    <= '0;
            r_nand   <= '0;
            r_nor    <= '0;
            r_xor    <= '0;
            r_xnor   <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_and    <= w_and;
                r_or     <= w_or;
                r_not    <= w_not;
                r_nand   <= w_nand;
                r_nor    <= w_nor;
                r_xor    <= w_xor;
                r_xnor   <= w_xnor;
                r_result <= w_result;
            end
        end
    end

    assign and_out   = r_and;
    assign or_out    = r_or;
    assign not_out   = r_not;
    assign nand_out  = r_nand;
    assign nor_out   = r_nor;
    assign xor_out   = r_xor;
    assign xnor_out  = r_xnor;
    assign result    = r_result;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_logic_gates.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_gates
// Brief    : Self-checking bench for logic_gates at WIDTH=1 and WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_logic_gates;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       a1, b1, v1;
    logic [2:0] op1;
    logic       and1, or1, not1, nand1, nor1, xor1, xnor1, res1, ov1;

    logic [7:0] a8, b8;
    logic       v8;
    logic [2:0] op8;
    logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8, res8;
    logic       ov8;

    logic_gates #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .in_valid(v1), .op_sel(op1),
        .and_out(and1), .or_out(or1), .not_out(not1), .nand_out(nand1),
        .nor_out(nor1), .xor_out(xor1), .xnor_out(xnor1), .result(res1),
        .out_valid(ov1)
    );

    logic_gates #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .in_valid(v8), .op_sel(op8),
        .and_out(and8), .or_out(or8), .not_out(not8), .nand_out(nand8),
        .nor_out(nor8), .xor_out(xor8), .xnor_out(xnor8), .result(res8),
        .out_valid(ov8)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: fields ordered and,or,not,nand,nor,xor,xnor,result.
    logic [7:0]      m1;
    logic            mv1;
    logic [7:0][7:0] m8;
    logic            mv8;

    function automatic logic [7:0][7:0] gates(input logic [7:0] a, input logic [7:0] b,
                                              input logic [2:0] op);
        logic [7:0] g [8];
        g[0] = a & b;    g[1] = a | b;    g[2] = ~a;        g[3] = ~(a & b);
        g[4] = ~(a | b); g[5] = a ^ b;    g[6] = ~(a ^ b);  g[7] = a;
        return {g[0], g[1], g[2], g[3], g[4], g[5], g[6], g[op]};
    endfunction

    function automatic logic [8:0] act1();
        return {and1, or1, not1, nand1, nor1, xor1, xnor1, res1, ov1};
    endfunction

    function automatic logic [64:0] act8();
        return {and8, or8, not8, nand8, nor8, xor8, xnor8, res8, ov8};
    endfunction

    // Advance one clock edge and apply the model's rules for that edge.
    task automatic tick();
        logic [7:0][7:0] g;
        @(posedge clk);
        if (rst) begin
            m1 = '0; mv1 = 1'b0; m8 = '0; mv8 = 1'b0;
        end else begin
            mv1 = v1;
            mv8 = v8;
            if (v1) begin
                g = gates({7'd0, a1}, {7'd0, b1}, op1);
                for (int k = 0; k < 8; k++) m1[k] = g[k][0];
            end
            if (v8) m8 = gates(a8, b8, op8);
        end
        #1;
    endtask

    task automatic drive_idle();
        @(negedge clk);
        rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; v1 = 1'b0; v8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; op1 = 3'd0; a8 = '0; b8 = '0; op8 = 3'd0;
        tick(); tick();
        checks++;
        if (act1() !== 9'd0) begin
            failures++; $display("FAIL reset_w1 got=%h exp=%h", act1(), 9'd0);
        end
        checks++;
        if (act8() !== 65'd0) begin
            failures++; $display("FAIL reset_w8 got=%h exp=%h", act8(), 65'd0);
        end
        // Sample on reset edge is discarded.
        @(negedge clk);
        rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd0;
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; op8 = 3'd0;
        tick();
        checks++;
        if (act1() !== 9'd0 || act8() !== 65'd0) begin
            failures++;
            $display("FAIL reset_same_edge got1=%h got8=%h exp=0", act1(), act8());
        end
        drive_idle(); tick();
        checks++;
        if (act1() !== 9'd0 || act8() !== 65'd0) begin
            failures++;
            $display("FAIL reset_release_idle got1=%h got8=%h exp=0", act1(), act8());
        end
    endtask

    task automatic test_w1_directed();
        @(negedge clk);
        rst = 1'b0; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd0;
        tick();
        checks++;
        if (act1() !== 9'b1_1_0_0_0_0_1_1_1) begin
            failures++; $display("FAIL w1_a1b1 got=%b exp=%b", act1(), 9'b110000111);
        end
        @(negedge clk);
        a1 = 1'b0; b1 = 1'b1; op1 = 3'd5;
        tick();
        checks++;
        if (act1() !== 9'b0_1_1_1_0_1_0_1_1) begin
            failures++; $display("FAIL w1_a0b1 got=%b exp=%b", act1(), 9'b011101011);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a1 = 1'b0; b1 = i[0]; op1 = 3'd2;
            tick();
            checks++;
            if (not1 !== 1'b1 || res1 !== 1'b1 || ov1 !== 1'b1) begin
                failures++;
                $display("FAIL w1_not_ignores_b b=%0d got_not=%b got_res=%b exp=1", i, not1, res1);
            end
        end
        drive_idle(); tick();
    endtask

    task automatic test_w8_hold();
        @(negedge clk);
        rst = 1'b0; v8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C; op8 = 3'd5;
        tick();
        checks++;
        if (res8 !== 8'hCC || and8 !== 8'h30 || ov8 !== 1'b1) begin
            failures++;
            $display("FAIL w8_xor result=%h and=%h ov=%b exp CC 30 1", res8, and8, ov8);
        end
        @(negedge clk);
        v8 = 1'b0; a8 = 8'h0F; b8 = 8'hA5; op8 = 3'd7;
        tick();
        checks++;
        if (res8 !== 8'hCC || and8 !== 8'h30 || or8 !== 8'hFC || not8 !== 8'h0F
            || ov8 !== 1'b0) begin
            failures++;
            $display("FAIL w8_hold result=%h and=%h or=%h not=%h ov=%b exp CC 30 FC 0F 0",
                     res8, and8, or8, not8, ov8);
        end
        // Undefined operands while idle must not disturb outputs.
        @(negedge clk);
        a8 = 'x; b8 = 'x; op8 = 'x;
        tick();
        checks++;
        if (act8() !== {m8, mv8}) begin
            failures++; $display("FAIL w8_idle_x got=%h exp=%h", act8(), {m8, mv8});
        end
    endtask

    task automatic test_w1_sweep();
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rst = 1'b0; v1 = 1'b1;
            a1 = i[4]; b1 = i[3]; op1 = i[2:0];
            tick();
            checks++;
            if (act1() !== {m1, mv1}) begin
                failures++;
                $display("FAIL w1_sweep a=%b b=%b op=%0d got=%b exp=%b",
                         a1, b1, op1, act1(), {m1, mv1});
            end
        end
        drive_idle(); tick();
        checks++;
        if (ov1 !== 1'b0 || act1() !== {m1, 1'b0}) begin
            failures++; $display("FAIL w1_sweep_end got=%b exp=%b", act1(), {m1, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 29) == 0);
            v1 = $urandom_range(0, 2) != 0; a1 = $urandom; b1 = $urandom; op1 = $urandom;
            v8 = $urandom_range(0, 2) != 0; a8 = $urandom; b8 = $urandom; op8 = $urandom;
            tick();
            checks++;
            if (act1() !== {m1, mv1}) begin
                failures++; $display("FAIL rand_w1 cyc=%0d got=%b exp=%b", i, act1(), {m1, mv1});
            end
            checks++;
            if (act8() !== {m8, mv8}) begin
                failures++; $display("FAIL rand_w8 cyc=%0d got=%h exp=%h", i, act8(), {m8, mv8});
            end
        end
        drive_idle(); tick();
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst = (i == 4);
            v8 = 1'b1; a8 = $urandom | 8'h01; b8 = $urandom; op8 = 3'd7;
            v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; op1 = 3'd7;
            tick();
            if (i == 4) begin
                checks++;
                if (act8() !== 65'd0 || act1() !== 9'd0) begin
                    failures++;
                    $display("FAIL reset_midstream got1=%b got8=%h exp=0", act1(), act8());
                end
            end else begin
                checks++;
                if (act8() !== {m8, mv8} || ov8 !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_b2b cyc=%0d got=%h exp=%h", i, act8(), {m8, mv8});
                end
            end
        end
        drive_idle(); tick();
    endtask

    initial begin
        m1 = '0; mv1 = 1'b0; m8 = '0; mv8 = 1'b0;
        rst = 1'b1; v1 = 1'b0; v8 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; op1 = '0; a8 = '0; b8 = '0; op8 = '0;
        test_reset();
        test_w1_directed();
        test_w8_hold();
        test_w1_sweep();
        test_random();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
